// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl
//   Run controller for the serial pattern-detection path. A pattern
//   configuration (pattern bits, length, match target) is loaded through a
//   valid/ready handshake while idle. The start input arms a run. The run scans
//   qualified serial bits for overlapping occurrences of the pattern and counts
//   them. The run ends with a one-cycle done pulse when the target is reached,
//   or it returns to idle on abort.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-low reset
//   cfg_valid    configuration offered
//   cfg_ready    configuration accepted (high while idle)
//   cfg_pattern  pattern, bit len-1 = first bit received, bit 0 = last
//   cfg_len      pattern length, legal 1..PAT_W
//   cfg_target   matches before done, 0 = unlimited
//   cfg_err      one-cycle pulse when an illegal cfg_len is rejected
//   start        arm detection (honoured only while idle)
//   abort        stop the run without done
//   in_valid     serial bit qualifier
//   in           serial data bit
//   match        one-cycle pulse per detected occurrence
//   match_count  matches in the current or last run
//   busy         high while a run is in progress
//   done         one-cycle pulse after the target-reaching match
module seq_detect_ctrl #(
   parameter int PAT_W = 8,
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_valid,
   output logic             cfg_ready,
   input  logic [PAT_W-1:0] cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic [CNT_W-1:0] cfg_target,
   output logic             cfg_err,
   input  logic             start,
   input  logic             abort,
   input  logic             in_valid,
   input  logic             in,
   output logic             match,
   output logic [CNT_W-1:0] match_count,
   output logic             busy,
   output logic             done
);

   localparam int SEEN_W = $clog2(PAT_W + 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t             state, state_nxt;
   logic [PAT_W-1:0]   pat_q, pat_nxt;
   logic [3:0]         len_q, len_nxt;
   logic [CNT_W-1:0]   tgt_q, tgt_nxt;
   // The oldest history bit is shifted out before any pattern can inspect it,
   // so only PAT_W-1 bits are kept; the incoming bit completes the window.
   logic [PAT_W-2:0]   hist_q, hist_nxt;
   logic [SEEN_W-1:0]  seen_q, seen_nxt;
   logic [CNT_W-1:0]   cnt_q, cnt_nxt;
   // Set by the target-reaching match so that DONE follows one cycle later.
   logic               hit_q, hit_nxt;
   logic               match_q, match_nxt;
   logic               err_q, err_nxt;

   logic [PAT_W-1:0]   hist_new;
   logic [SEEN_W-1:0]  seen_new;
   logic [CNT_W-1:0]   cnt_new;
   logic [PAT_W-1:0]   mask;
   logic               is_match;
   logic               len_legal;

   function automatic logic [CNT_W-1:0] sat_cnt_inc(input logic [CNT_W-1:0] c);
      if (&c) return c;
      return c + CNT_W'(1);
   endfunction

   function automatic logic [SEEN_W-1:0] sat_seen_inc(input logic [SEEN_W-1:0] s);
      if (32'(s) < PAT_W) return s + SEEN_W'(1);
      return s;
   endfunction

   function automatic logic [PAT_W-1:0] len_mask(input logic [3:0] l);
      logic [PAT_W:0] m;
      m = ((PAT_W + 1)'(1) << l) - (PAT_W + 1)'(1);
      return m[PAT_W-1:0];
   endfunction

   assign hist_new  = {hist_q, in};
   assign seen_new  = sat_seen_inc(seen_q);
   assign cnt_new   = sat_cnt_inc(cnt_q);
   assign mask      = len_mask(len_q);
   assign is_match  = (32'(seen_new) >= 32'(len_q)) &&
                      ((hist_new & mask) == (pat_q & mask));
   assign len_legal = (cfg_len != 4'd0) && (32'(cfg_len) <= PAT_W);

   always_comb begin
      state_nxt = state;
      pat_nxt   = pat_q;
      len_nxt   = len_q;
      tgt_nxt   = tgt_q;
      hist_nxt  = hist_q;
      seen_nxt  = seen_q;
      cnt_nxt   = cnt_q;
      hit_nxt   = hit_q;
      match_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (cfg_valid) begin
               if (len_legal) begin
                  pat_nxt = cfg_pattern;
                  len_nxt = cfg_len;
                  tgt_nxt = cfg_target;
               end else begin
                  err_nxt = 1'b1;
               end
            end
            if (start) begin
               state_nxt = RUN;
               hist_nxt  = '0;
               seen_nxt  = '0;
               cnt_nxt   = '0;
               hit_nxt   = 1'b0;
            end
         end
         RUN: begin
            if (abort) begin
               state_nxt = IDLE;
               hit_nxt   = 1'b0;
            end else if (hit_q) begin
               state_nxt = DONE;
               hit_nxt   = 1'b0;
            end else if (in_valid) begin
               hist_nxt = hist_new[PAT_W-2:0];
               seen_nxt = seen_new;
               if (is_match) begin
                  match_nxt = 1'b1;
                  cnt_nxt   = cnt_new;
                  if ((tgt_q != '0) && (cnt_new == tgt_q)) hit_nxt = 1'b1;
               end
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         pat_q   <= '0;
         len_q   <= 4'd1;
         tgt_q   <= '0;
         hist_q  <= '0;
         seen_q  <= '0;
         cnt_q   <= '0;
         hit_q   <= 1'b0;
         match_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state   <= state_nxt;
         pat_q   <= pat_nxt;
         len_q   <= len_nxt;
         tgt_q   <= tgt_nxt;
         hist_q  <= hist_nxt;
         seen_q  <= seen_nxt;
         cnt_q   <= cnt_nxt;
         hit_q   <= hit_nxt;
         match_q <= match_nxt;
         err_q   <= err_nxt;
      end
   end

   assign cfg_ready   = (state == IDLE);
   assign busy        = (state == RUN);
   assign done        = (state == DONE);
   assign match       = match_q;
   assign match_count = cnt_q;
   assign cfg_err     = err_q;

endmodule
